// File: rtl/niosII_system_sysid_pkg.sv
// -----------------------------------------------------------------------------
// niosII_system_sysid_pkg
// Shared types and constants for the system-ID checker:
//   - sysid_state_t           : checker FSM states
//   - SYSID_ADDR_ID / _TS     : word addresses of the ID and timestamp registers
//   - SYSID_DEFAULT_TIMESTAMP : default expected timestamp word
//   - is_busy_state / is_req_state : state classification helpers
// -----------------------------------------------------------------------------
package niosII_system_sysid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ID_REQ  = 3'd1,
      ST_ID_WAIT = 3'd2,
      ST_TS_REQ  = 3'd3,
      ST_TS_WAIT = 3'd4,
      ST_DONE    = 3'd5
   } sysid_state_t;

   localparam logic        SYSID_ADDR_ID           = 1'b0;
   localparam logic        SYSID_ADDR_TS           = 1'b1;
   localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1490127728;

   // A check is in progress in every state except IDLE and DONE.
   function automatic logic is_busy_state(input sysid_state_t s);
      return (s != ST_IDLE) && (s != ST_DONE);
   endfunction

   // States that present a read request on the bus.
   function automatic logic is_req_state(input sysid_state_t s);
      return (s == ST_ID_REQ) || (s == ST_TS_REQ);
   endfunction

endpackage

// File: rtl/niosII_system_sysid_timeout.sv
// -----------------------------------------------------------------------------
// niosII_system_sysid_timeout
// Phase watchdog for the system-ID checker. Counts cycles spent in one
// request or wait phase and flags expiry on the last permitted cycle.
// Ports:
//   clock     in  rising-edge clock
//   reset_n   in  asynchronous active-low reset
//   i_clear   in  restart the count (asserted on every phase change)
//   i_enable  in  count this cycle (checker is in a REQ or WAIT phase)
//   o_expired out phase has used TIMEOUT_CYCLES-1 counted cycles
// -----------------------------------------------------------------------------
module niosII_system_sysid_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);
   localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   logic [CW-1:0] r_count;

   // Phase cycle counter; saturates at LAST so it never wraps.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// niosii_system_sysid_checker
// Avalon-MM read master that reads the sysid ID word (address 0) and the
// timestamp word (address 1), compares them with expected values and latches
// the results as status flags.
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   start                single-cycle request to (re)run a check (ignored while busy)
//   address, read        Avalon request (registered)
//   waitrequest          slave stall
//   readdata/readdatavalid  slave response
//   busy, done           check in progress / finished (done held until next start)
//   id_ok, ts_ok         captured words matched the expected values
//   timeout              check aborted because a phase took too long
//   id_value, ts_value   captured words
// -----------------------------------------------------------------------------
module niosii_system_sysid_checker
   import niosII_system_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   input  logic        readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   sysid_state_t r_state;
   sysid_state_t w_next_state;
   logic         r_auto_pending;
   logic         w_id_capture;
   logic         w_ts_capture;
   logic         w_abort;
   logic         w_expired;
   logic         w_phase_clear;
   logic         w_phase_active;
   logic         w_check_start;

   logic         r_read;
   logic         r_address;
   logic         r_busy;
   logic         r_done;
   logic         r_id_ok;
   logic         r_ts_ok;
   logic         r_timeout;
   logic [31:0]  r_id_value;
   logic [31:0]  r_ts_value;

   // Counter restarts on every state change, runs only inside REQ/WAIT phases.
   assign w_phase_clear  = (w_next_state != r_state);
   assign w_phase_active = is_busy_state(r_state);
   assign w_check_start  = !is_busy_state(r_state) && (w_next_state == ST_ID_REQ);

   niosII_system_sysid_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_clear   (w_phase_clear),
      .i_enable  (w_phase_active),
      .o_expired (w_expired)
   );

   // State register; the auto-start request is armed by reset and consumed on leaving IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_auto_pending <= AUTO_START;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_IDLE) begin
            r_auto_pending <= 1'b0;
         end else begin
            r_auto_pending <= r_auto_pending;
         end
      end
   end

   // Next-state logic; phase completion is tested before expiry so it wins a tie.
   always_comb begin
      w_next_state = r_state;
      w_id_capture = 1'b0;
      w_ts_capture = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_auto_pending || start) begin
               w_next_state = ST_ID_REQ;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ID_REQ, ST_TS_REQ: begin
            if (!waitrequest) begin
               w_next_state = (r_state == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
            end else if (w_expired) begin
               w_next_state = ST_DONE;
               w_abort      = 1'b1;
            end else begin
               w_next_state = r_state;
            end
         end
         ST_ID_WAIT, ST_TS_WAIT: begin
            if (readdatavalid) begin
               w_next_state = (r_state == ST_ID_WAIT) ? ST_TS_REQ : ST_DONE;
               w_id_capture = (r_state == ST_ID_WAIT);
               w_ts_capture = (r_state == ST_TS_WAIT);
            end else if (w_expired) begin
               w_next_state = ST_DONE;
               w_abort      = 1'b1;
            end else begin
               w_next_state = r_state;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_next_state = ST_ID_REQ;
            end else begin
               w_next_state = ST_DONE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Registered bus and status outputs, decoded from the state being entered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_read     <= 1'b0;
         r_address  <= SYSID_ADDR_ID;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= 32'd0;
         r_ts_value <= 32'd0;
      end else begin
         r_read <= is_req_state(w_next_state);
         r_busy <= is_busy_state(w_next_state);
         r_done <= (w_next_state == ST_DONE);

         // Address is only meaningful while read is high; hold it otherwise.
         if (w_next_state == ST_ID_REQ) begin
            r_address <= SYSID_ADDR_ID;
         end else if (w_next_state == ST_TS_REQ) begin
            r_address <= SYSID_ADDR_TS;
         end else begin
            r_address <= r_address;
         end

         if (w_check_start) begin
            r_timeout <= 1'b0;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
         end else if (w_abort) begin
            // An aborted check reports no match even if the ID was already captured.
            r_timeout <= 1'b1;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
         end else begin
            r_timeout <= r_timeout;
            r_id_ok   <= w_id_capture ? (readdata == EXPECTED_ID)        : r_id_ok;
            r_ts_ok   <= w_ts_capture ? (readdata == EXPECTED_TIMESTAMP) : r_ts_ok;
         end

         r_id_value <= w_id_capture ? readdata : r_id_value;
         r_ts_value <= w_ts_capture ? readdata : r_ts_value;
      end
   end

   assign read     = r_read;
   assign address  = r_address;
   assign busy     = r_busy;
   assign done     = r_done;
   assign id_ok    = r_id_ok;
   assign ts_ok    = r_ts_ok;
   assign timeout  = r_timeout;
   assign id_value = r_id_value;
   assign ts_value = r_ts_value;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_niosii_system_sysid_checker
// Self-checking bench: a configurable Avalon slave answers the checker; the
// expected completion edge and flags come from a phase-duration model.
// -----------------------------------------------------------------------------
module tb_niosii_system_sysid_checker;

   localparam int          TB_TO  = 8;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1490127728;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   int checks = 0;
   int errors = 0;

   // slave configuration (written by the test thread only)
   int          wait_cfg [2];
   int          dly_cfg  [2];   // 0 = never respond
   logic [31:0] data_cfg [2];
   bit          stray_rdv;
   logic [31:0] stray_data;

   // slave internal state (written by the slave process only)
   int   stall_cnt;
   int   cnt_left;
   bit   acc_pending;
   bit   active;
   logic acc_addr;
   logic pend_addr;

   // reference values carried across checks
   logic [31:0] model_id_value;
   logic [31:0] model_ts_value;

   always #5 clock = ~clock;

   niosii_system_sysid_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .TIMEOUT_CYCLES     (TB_TO),
      .AUTO_START         (1'b1)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .address       (address),
      .read          (read),
      .waitrequest   (waitrequest),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .busy          (busy),
      .done          (done),
      .id_ok         (id_ok),
      .ts_ok         (ts_ok),
      .timeout       (timeout),
      .id_value      (id_value),
      .ts_value      (ts_value)
   );

   // Slave model: stalls wait_cfg cycles, returns data dly_cfg cycles after acceptance.
   always @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         waitrequest   = 1'b0;
         readdatavalid = 1'b0;
         readdata      = 32'd0;
         stall_cnt     = 0;
         cnt_left      = 0;
         acc_pending   = 1'b0;
         active        = 1'b0;
      end else begin
         readdatavalid = 1'b0;
         if (acc_pending) begin
            acc_pending = 1'b0;
            active      = (dly_cfg[acc_addr] != 0);
            cnt_left    = dly_cfg[acc_addr];
            pend_addr   = acc_addr;
         end
         if (active) begin
            if (cnt_left == 1) begin
               readdatavalid = 1'b1;
               readdata      = data_cfg[pend_addr];
               active        = 1'b0;
            end else begin
               cnt_left = cnt_left - 1;
            end
         end
         if (stray_rdv) begin
            readdatavalid = 1'b1;
            readdata      = stray_data;
         end
         if (read === 1'b1) begin
            if (stall_cnt < wait_cfg[address]) begin
               waitrequest = 1'b1;
               stall_cnt   = stall_cnt + 1;
            end else begin
               waitrequest = 1'b0;
               stall_cnt   = 0;
               acc_pending = 1'b1;
               acc_addr    = address;
            end
         end else begin
            waitrequest = 1'b0;
            stall_cnt   = 0;
         end
      end
   end

   // Edges from ID_REQ entry to DONE, from the per-phase durations and the timeout rule.
   function automatic int model_latency(input int wi, input int di, input int wt, input int dt,
                                        output bit to, output bit got_id, output bit got_ts);
      int t;
      to = 1'b0; got_id = 1'b0; got_ts = 1'b0;
      if (wi + 1 > TB_TO) begin to = 1'b1; return TB_TO; end
      t = wi + 1;
      if (di == 0 || di > TB_TO) begin to = 1'b1; return t + TB_TO; end
      t = t + di; got_id = 1'b1;
      if (wt + 1 > TB_TO) begin to = 1'b1; return t + TB_TO; end
      t = t + wt + 1;
      if (dt == 0 || dt > TB_TO) begin to = 1'b1; return t + TB_TO; end
      t = t + dt; got_ts = 1'b1;
      return t;
   endfunction

   task automatic sample();
      @(negedge clock);
      #1;
   endtask

   // One full check: trigger (start pulse or auto-start), track every cycle, check the result.
   task automatic run_check(input string name, input int wi, input int di, input int wt, input int dt,
                            input logic [31:0] idd, input logic [31:0] tsd,
                            input bit use_start, input bit start_mid);
      int   lat, edges, ts_wait_entry;
      bit   to, got_id, got_ts, exp_id_ok, exp_ts_ok;
      logic pr_read, pr_addr, pr_wr;
      wait_cfg[0] = wi; dly_cfg[0] = di; data_cfg[0] = idd;
      wait_cfg[1] = wt; dly_cfg[1] = dt; data_cfg[1] = tsd;
      lat = model_latency(wi, di, wt, dt, to, got_id, got_ts);
      if (got_id) model_id_value = idd;
      if (got_ts) model_ts_value = tsd;
      exp_id_ok = !to && (idd == EXP_ID);
      exp_ts_ok = !to && (tsd == EXP_TS);
      ts_wait_entry = 1 + (wi + 1) + di + (wt + 1);

      if (use_start) start = 1'b1;
      @(posedge clock);
      sample();
      start = 1'b0;
      edges = 1;
      checks++;
      if (read !== 1'b1 || address !== 1'b0 || busy !== 1'b1 || done !== 1'b0 ||
          timeout !== 1'b0 || id_ok !== 1'b0 || ts_ok !== 1'b0) begin
         errors++;
         $display("FAIL %s first_edge: read=%b addr=%b busy=%b done=%b timeout=%b id_ok=%b ts_ok=%b, expected 1 0 1 0 0 0 0",
                  name, read, address, busy, done, timeout, id_ok, ts_ok);
      end
      pr_read = read; pr_addr = address; pr_wr = waitrequest;
      while (edges < 1 + lat) begin
         if (start_mid && edges == ts_wait_entry) start = 1'b1;
         sample();
         start = 1'b0;
         edges++;
         if (edges < 1 + lat) begin
            if (pr_read === 1'b1 && pr_wr === 1'b1) begin
               checks++;
               if (read !== 1'b1 || address !== pr_addr) begin
                  errors++;
                  $display("FAIL %s stall_hold edge %0d: read=%b addr=%b, expected 1 %b",
                           name, edges, read, address, pr_addr);
               end
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL %s in_progress edge %0d: done=%b busy=%b, expected 0 1",
                        name, edges, done, busy);
            end
         end
         pr_read = read; pr_addr = address; pr_wr = waitrequest;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || read !== 1'b0) begin
         errors++;
         $display("FAIL %s completion edge %0d: done=%b busy=%b read=%b, expected 1 0 0",
                  name, edges, done, busy, read);
      end
      checks++;
      if (timeout !== to || id_ok !== exp_id_ok || ts_ok !== exp_ts_ok) begin
         errors++;
         $display("FAIL %s flags: timeout=%b id_ok=%b ts_ok=%b, expected %b %b %b",
                  name, timeout, id_ok, ts_ok, to, exp_id_ok, exp_ts_ok);
      end
      checks++;
      if (id_value !== model_id_value || ts_value !== model_ts_value) begin
         errors++;
         $display("FAIL %s values: id=%h ts=%h, expected %h %h",
                  name, id_value, ts_value, model_id_value, model_ts_value);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; stray_rdv = 1'b0; stray_data = 32'd0;
      model_id_value = 32'd0; model_ts_value = 32'd0;
      for (int i = 0; i < 2; i++) begin
         wait_cfg[i] = 0; dly_cfg[i] = 1; data_cfg[i] = 32'd0;
      end
      repeat (3) sample();
      checks++;
      if ({read, address, busy, done, id_ok, ts_ok, timeout} !== 7'd0 ||
          id_value !== 32'd0 || ts_value !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: read=%b addr=%b busy=%b done=%b id_ok=%b ts_ok=%b timeout=%b id=%h ts=%h, expected all 0",
                  read, address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value);
      end
   endtask

   task automatic test_nominal();
      reset_n = 1'b1;
      run_check("nominal_auto", 0, 1, 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
   endtask

   task automatic test_wait_states();
      run_check("wait_states", 3, 1, 3, 1, EXP_ID, EXP_TS, 1'b1, 1'b0);
   endtask

   task automatic test_mismatch();
      run_check("id_mismatch", 0, 1, 0, 1, 32'h1, EXP_TS, 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      run_check("timeout_id_wait", 0, 0, 0, 1, EXP_ID, EXP_TS, 1'b1, 1'b0);
      run_check("timeout_ts_req", 0, 1, 8, 1, EXP_ID, EXP_TS, 1'b1, 1'b0);
   endtask

   task automatic test_boundary();
      // completion on the last permitted cycle of every phase
      run_check("boundary_last_cycle", 7, 8, 7, 8, EXP_ID, EXP_TS, 1'b1, 1'b0);
   endtask

   task automatic test_restart();
      run_check("start_in_ts_wait", 0, 1, 0, 3, EXP_ID, EXP_TS, 1'b1, 1'b1);
   endtask

   task automatic test_stray_rdv();
      stray_data = 32'hDEAD_BEEF;
      stray_rdv  = 1'b1;
      sample();
      stray_rdv  = 1'b0;
      sample();
      checks++;
      if (id_value !== model_id_value || ts_value !== model_ts_value || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stray_rdv: id=%h ts=%h done=%b busy=%b, expected %h %h 1 0",
                  id_value, ts_value, done, busy, model_id_value, model_ts_value);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         int          wi, di, wt, dt;
         logic [31:0] idd, tsd;
         wi  = int'($urandom_range(0, 8));
         di  = int'($urandom_range(0, 8));
         wt  = int'($urandom_range(0, 8));
         dt  = int'($urandom_range(0, 8));
         idd = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
         tsd = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
         run_check($sformatf("random_%0d", n), wi, di, wt, dt, idd, tsd, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset_mid_read();
      wait_cfg[0] = 50;
      start = 1'b1;
      @(posedge clock);
      sample();
      start = 1'b0;
      repeat (2) sample();
      checks++;
      if (read !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_read_stalled: read=%b busy=%b, expected 1 1", read, busy);
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (read !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || id_value !== 32'd0 || ts_value !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: read=%b busy=%b done=%b id=%h ts=%h, expected 0 0 0 0 0",
                  read, busy, done, id_value, ts_value);
      end
      model_id_value = 32'd0;
      model_ts_value = 32'd0;
      sample();
      reset_n = 1'b1;
      run_check("after_reset_auto", 0, 2, 1, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_wait_states();
      test_mismatch();
      test_timeout();
      test_boundary();
      test_restart();
      test_stray_rdv();
      test_random();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
